// File: rtl/io_handshake_host.sv
// io_handshake_host: drives operands onto in_bus with a timed io_handshake pulse and
// captures out_bus once after every group of OPS_PER_RESULT operands.
module io_handshake_host #(
    parameter int WIDTH          = 8,
    parameter int HIGH_CYCLES    = 16,
    parameter int LOW_CYCLES     = 16,
    parameter int OPS_PER_RESULT = 2,
    parameter int SETTLE_CYCLES  = 32
) (
    input  logic             clk,
    input  logic             n_reset,
    input  logic             flush,
    input  logic [WIDTH-1:0] op_data,
    input  logic             op_valid,
    output logic             op_ready,
    output logic [WIDTH-1:0] in_bus,
    output logic             io_handshake,
    input  logic [WIDTH-1:0] out_bus,
    output logic [WIDTH-1:0] res_data,
    output logic             res_valid,
    output logic             busy
);
    localparam int MAXHL = HIGH_CYCLES > LOW_CYCLES ? HIGH_CYCLES : LOW_CYCLES;
    localparam int MAXC  = MAXHL > SETTLE_CYCLES ? MAXHL : SETTLE_CYCLES;
    localparam int CW    = $clog2(MAXC + 1);
    localparam int OW    = $clog2(OPS_PER_RESULT + 1);
    localparam logic [CW-1:0] H_END = CW'(HIGH_CYCLES - 1);
    localparam logic [CW-1:0] L_END = CW'(LOW_CYCLES - 1);
    localparam logic [CW-1:0] S_END = CW'(SETTLE_CYCLES - 1);
    localparam logic [OW-1:0] O_END = OW'(OPS_PER_RESULT - 1);

    if (HIGH_CYCLES < 1 || LOW_CYCLES < 1 || OPS_PER_RESULT < 1 || SETTLE_CYCLES < 1) begin : g_param_check
        $error("io_handshake_host: HIGH/LOW/SETTLE_CYCLES and OPS_PER_RESULT must be >= 1");
    end

    typedef enum logic [2:0] {IDLE, SETUP, HIGH, LOW, SETTLE, CAPTURE} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt;
    logic [OW-1:0] ops;
    logic          xfer, timed, last;

    assign op_ready = state == IDLE;
    assign busy     = !op_ready;
    assign xfer     = op_valid && op_ready && !flush;
    assign last     = ops == O_END;
    assign timed    = state == HIGH || state == LOW || state == SETTLE;

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = op_valid ? SETUP : IDLE;
            SETUP:   state_n = HIGH;
            HIGH:    state_n = cnt == H_END ? LOW : HIGH;
            LOW:     state_n = cnt != L_END ? LOW : last ? SETTLE : IDLE;
            SETTLE:  state_n = cnt == S_END ? CAPTURE : SETTLE;
            CAPTURE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (flush) state_n = IDLE;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) state <= IDLE;
        else          state <= state_n;
    end

    // Phase counter restarts on every state change, so it only ever counts within one phase
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt          <= '0;
            ops          <= '0;
            in_bus       <= '0;
            io_handshake <= 1'b0;
            res_data     <= '0;
            res_valid    <= 1'b0;
        end else begin
            cnt          <= state_n != state ? '0 : cnt + CW'(timed);
            ops          <= flush ? '0 : (state == LOW && cnt == L_END) ? (last ? '0 : ops + OW'(1)) : ops;
            io_handshake <= state_n == HIGH;
            res_valid    <= state == CAPTURE && !flush;
            if (xfer) in_bus <= op_data;
            if (state == CAPTURE && !flush) res_data <= out_bus;
        end
    end
endmodule

// File: tb/tb_io_handshake_host.sv
// tb_io_handshake_host: random operand/flush traffic checked against a cycle-timeline model;
// results are scored from a queue of expected capture edges.
module tb_io_handshake_host;
    localparam int W = 8, H = 4, L = 4, S = 3, O = 2;

    logic         clk = 0, n_reset = 0, flush = 0, op_valid = 0;
    logic [W-1:0] op_data = 0, out_bus = 0;
    logic         op_ready, io_handshake, res_valid, busy;
    logic [W-1:0] in_bus, res_data;

    io_handshake_host #(.WIDTH(W), .HIGH_CYCLES(H), .LOW_CYCLES(L), .OPS_PER_RESULT(O), .SETTLE_CYCLES(S)) dut (
        .clk(clk), .n_reset(n_reset), .flush(flush), .op_data(op_data), .op_valid(op_valid),
        .op_ready(op_ready), .in_bus(in_bus), .io_handshake(io_handshake), .out_bus(out_bus),
        .res_data(res_data), .res_valid(res_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0, failures = 0;
    int q[$];
    logic [W-1:0] ob[int];
    int busy_until = 0, hs_from = 1, hs_to = 0, g = 0;
    logic [W-1:0] in_exp = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Model: a transfer before edge e gives handshake high after edges e+1..e+H and ready
    // again after e+1+H+L, plus S+1 and a capture at that edge when it closes a group.
    task automatic step(input logic v, input logic [W-1:0] d, input logic f);
        int e;
        @(negedge clk);
        chk("op_ready", 32'(op_ready), 32'(cyc >= busy_until));
        chk("busy", 32'(busy), 32'(cyc < busy_until));
        chk("io_handshake", 32'(io_handshake), 32'(cyc >= hs_from && cyc <= hs_to));
        chk("in_bus", 32'(in_bus), 32'(in_exp));
        op_valid = v;
        op_data  = d;
        flush    = f;
        out_bus  = W'($urandom);
        ob[cyc]  = out_bus;
        if (f) begin
            if (busy_until > cyc + 1) busy_until = cyc + 1;
            if (hs_to > cyc) hs_to = cyc;
            g = 0;
            while (q.size() > 0 && q[$] > cyc) void'(q.pop_back());
        end else if (v && cyc >= busy_until) begin
            e       = cyc + 1;
            in_exp  = d;
            hs_from = e + 1;
            hs_to   = e + H;
            g++;
            if (g == O) begin
                g = 0;
                busy_until = e + 1 + H + L + S + 1;
                q.push_back(busy_until);
            end else busy_until = e + 1 + H + L;
        end
    endtask

    always @(negedge clk) begin
        while (q.size() > 0 && q[0] < cyc) begin
            checks++;
            failures++;
            $display("FAIL res_missing cyc=%0d got=none expected_at=%0d", cyc, q[0]);
            void'(q.pop_front());
        end
        if (res_valid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL res_unexpected cyc=%0d got=%0h expected=none", cyc, res_data);
            end else begin
                int c;
                c = q.pop_front();
                chk("res_time", 32'(cyc), 32'(c));
                chk("res_data", 32'(res_data), 32'(ob[c-1]));
            end
        end
    end

    initial begin
        repeat (3) step(0, 0, 0);
        n_reset = 1;
        repeat (6) step(0, 0, 0);
        repeat (1500) step($urandom_range(0, 3) != 0, W'($urandom), $urandom_range(0, 60) == 0);
        repeat (40) step(0, 0, 0);
        // async reset in the middle of a high phase
        step(1, 8'hA5, 0);
        repeat (3) step(0, 0, 0);
        chk("hs_before_reset", 32'(io_handshake), 32'(1));
        #2 n_reset = 0;
        #1;
        chk("reset_hs", 32'(io_handshake), 32'(0));
        chk("reset_in_bus", 32'(in_bus), 32'(0));
        chk("reset_ready", 32'(op_ready), 32'(1));
        chk("reset_res_valid", 32'(res_valid), 32'(0));
        busy_until = 0;
        hs_from    = 1;
        hs_to      = 0;
        g          = 0;
        in_exp     = 0;
        q.delete();
        repeat (3) step(0, 0, 0);
        n_reset = 1;
        repeat (120) step(1, W'($urandom), 0);
        repeat (40) step(0, 0, 0);
        chk("queue_drained", 32'(q.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/io_handshake_host.md
Name: io_handshake_host

Overview:
- Host-side driver for the processor's switch-level I/O protocol: the hardware equivalent of a user setting the data switches, toggling the handshake switch, then reading the LEDs.
- Accepts operand bytes on a valid/ready stream and presents each one on in_bus with a timed high-then-low pulse on io_handshake.
- After every OPS_PER_RESULT operands it waits for the processor to settle, captures out_bus, and emits it as a one-cycle result.
- Used for board self-test and as the stimulus engine in the system-level bench in place of SW[8:0].

Parameters:
WIDTH, 8, operand/result width (in_bus, out_bus)
HIGH_CYCLES, 16, clk cycles io_handshake is held high per operand (>=1)
LOW_CYCLES, 16, clk cycles io_handshake is held low after the high phase (>=1)
OPS_PER_RESULT, 2, operands per captured result (>=1)
SETTLE_CYCLES, 32, clk cycles between the end of the last operand's low phase and out_bus capture (>=1)

Ports:
clk  input  1  system clock (the same slow clock as the processor)
n_reset  input  1  asynchronous active-low reset
flush  input  1  synchronous abort; returns to IDLE
op_data  input  WIDTH  operand to present
op_valid  input  1  operand available
op_ready  output  1  high only in IDLE; transfer occurs on op_valid && op_ready at a rising edge
in_bus  output  WIDTH  data to the processor's input bus, registered
io_handshake  output  1  handshake to the processor, registered
out_bus  input  WIDTH  processor output bus
res_data  output  WIDTH  captured result, registered, held until the next capture
res_valid  output  1  one-cycle pulse when res_data updates
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values (async, n_reset low):
  - State IDLE; in_bus=0, io_handshake=0, res_data=0, res_valid=0.
  - Operand counter=0; all phase counters=0.
  - op_ready=1 and busy=0 from the first cycle after reset deasserts.
- States: IDLE, SETUP, HIGH, LOW, SETTLE, CAPTURE.
- IDLE:
  - On a transfer, in_bus<=op_data and go to SETUP.
  - When op_valid is low, stay in IDLE.
  - in_bus holds its last value in every state; it changes only on a transfer.
- SETUP: one cycle with io_handshake=0, so data is stable before the rising handshake. Then io_handshake<=1 and go to HIGH.
- HIGH:
  - Exactly HIGH_CYCLES cycles with io_handshake=1.
  - At the end, io_handshake<=0 and go to LOW.
- LOW:
  - Exactly LOW_CYCLES cycles with io_handshake=0.
  - At the end, increment the operand counter.
  - If the counter reaches OPS_PER_RESULT, clear it and go to SETTLE; otherwise go to IDLE.
- SETTLE: exactly SETTLE_CYCLES cycles, then go to CAPTURE.
- CAPTURE: one cycle. res_data<=out_bus and res_valid<=1 take effect at the CAPTURE-exit edge; go to IDLE.
- res_valid is therefore high during the first IDLE cycle after CAPTURE. That cycle may coincide with the next transfer.
- Latency:
  - Transfer to op_ready high again: 1+HIGH_CYCLES+LOW_CYCLES cycles for a non-final operand.
  - Add SETTLE_CYCLES+1 when the operand is the final one of a result.
- flush (synchronous, priority over everything except reset):
  - Next state IDLE; io_handshake<=0; operand counter<=0; no res_valid pulse.
  - in_bus and res_data keep their values.
  - flush in IDLE with op_valid high: no transfer that cycle.
- An asynchronous reset mid-pulse drops io_handshake immediately and abandons the partial operand group.
- op_valid while op_ready is low is ignored; upstream must hold op_data until the transfer.
- out_bus is sampled only in CAPTURE. Changes during other states have no effect.
- Counters are sized $clog2(max+1) and never wrap; each phase counter resets on state entry.
- Elaboration error if any parameter listed as >=1 is 0.

Test Plan:
1. Reset release with HIGH=4, LOW=4, SETTLE=3, OPS=2, op_valid=0 -> op_ready=1, busy=0, in_bus=0x00, io_handshake=0, res_valid=0 indefinitely.
2. Transfer op_data=0x5A at edge 0 -> in_bus=0x5A after edge 0; io_handshake high exactly cycles 2-5 (after edges 1-4), low after edge 5; op_ready=1 after edge 9; no res_valid.
3. Second transfer 0x03 with out_bus=0xC4 -> io_handshake high for 4 cycles; op_ready stays 0 through SETTLE and CAPTURE; exactly one res_valid pulse with res_data=0xC4, 1+4+4+3+1=13 edges after the transfer.
4. out_bus toggles 0x11/0x22 every cycle during SETTLE, then 0x77 in CAPTURE -> res_data=0x77.
5. flush asserted during HIGH of the first operand of a pair -> io_handshake=0 next cycle; IDLE; counter cleared. The next two operands produce exactly one result, and no result appears after only one operand.
6. n_reset pulsed low mid-HIGH -> io_handshake=0 and in_bus=0 asynchronously (before the next edge); state as in scenario 1 after release; back-to-back operands with op_valid held high -> one handshake pulse per operand, none merged or skipped.
